alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one external combinational ALU between two requesters.
//            A grant in IDLE captures the winner's operation. EXEC drives
//            those operands to the ALU for one cycle and registers the result.
//            RESP holds the result until the consumer takes it.
//            Arbitration is round-robin or fixed priority, set by
//            FIXED_PRIORITY.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            reqN_valid/ready     - requester N handshake (N = 0, 1)
//            reqN_a/b/ipsel/opsel - requester N operation
//            alu_a/b/ipsel/opsel  - operation driven to the shared ALU
//            alu_result/carry     - combinational ALU return
//            rsp_valid/ready      - response handshake
//            rsp_id/result/carry  - registered response payload
//            busy                 - high whenever not IDLE
//            ops_count            - completed responses, wraps at 16 bits
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_ipsel,
  input  logic [4:0]  req0_opsel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_ipsel,
  input  logic [4:0]  req1_opsel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_ipsel,
  output logic [4:0]  alu_opsel,
  input  logic [31:0] alu_result,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        busy,
  output logic [15:0] ops_count
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_exec = 2'd1;
  localparam logic [1:0] c_resp = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        op_ipsel_q, op_ipsel_d;
  logic [4:0]  op_opsel_q, op_opsel_d;
  logic        op_id_q, op_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] ops_count_q, ops_count_d;

  logic w_grant0;
  logic w_grant1;
  logic w_accept;

  // Grant logic. Grants are only possible in IDLE and never while reset is
  // asserted. In round-robin mode a contended grant goes to the requester
  // that did not win last time.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!rst && state_q == c_idle) begin
      if (FIXED_PRIORITY != 0) begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid & ~req0_valid;
      end else if (req0_valid && req1_valid) begin
        w_grant0 = last_grant_q;
        w_grant1 = ~last_grant_q;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  assign w_accept = w_grant0 | w_grant1;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:  if (w_accept) state_d = c_exec;
      c_exec:  state_d = c_resp;
      c_resp:  if (rsp_ready) state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  // Datapath next values: operation capture, result capture and counter
  always_comb begin
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_ipsel_d   = op_ipsel_q;
    op_opsel_d   = op_opsel_q;
    op_id_d      = op_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_id_d     = rsp_id_q;
    ops_count_d  = ops_count_q;
    if (w_accept) begin
      last_grant_d = w_grant1;
      op_id_d      = w_grant1;
      op_a_d       = w_grant1 ? req1_a     : req0_a;
      op_b_d       = w_grant1 ? req1_b     : req0_b;
      op_ipsel_d   = w_grant1 ? req1_ipsel : req0_ipsel;
      op_opsel_d   = w_grant1 ? req1_opsel : req0_opsel;
    end
    if (state_q == c_exec) begin
      rsp_result_d = alu_result;
      rsp_carry_d  = alu_carry;
      rsp_id_d     = op_id_q;
    end
    if (state_q == c_resp && rsp_ready) begin
      ops_count_d = ops_count_q + 16'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= c_idle;
      last_grant_q <= 1'b1;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      op_ipsel_q   <= 1'b0;
      op_opsel_q   <= 5'd0;
      op_id_q      <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_carry_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      ops_count_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_ipsel_q   <= op_ipsel_d;
      op_opsel_q   <= op_opsel_d;
      op_id_q      <= op_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_id_q     <= rsp_id_d;
      ops_count_q  <= ops_count_d;
    end
  end

  // Outputs. The ALU sees the captured operation only during EXEC and
  // zeros at all other times.
  always_comb begin
    req0_ready = w_grant0;
    req1_ready = w_grant1;
    rsp_valid  = (state_q == c_resp);
    busy       = (state_q != c_idle);
    alu_a      = 32'd0;
    alu_b      = 32'd0;
    alu_ipsel  = 1'b0;
    alu_opsel  = 5'd0;
    if (state_q == c_exec) begin
      alu_a     = op_a_q;
      alu_b     = op_b_q;
      alu_ipsel = op_ipsel_q;
      alu_opsel = op_opsel_q;
    end
  end

  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign ops_count  = ops_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. It drives one round-robin
//            instance and one fixed-priority instance. Each instance has a
//            small ALU model attached. Valid inputs are steered to one
//            instance at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        sel_fp = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        ip0 = 1'b0, ip1 = 1'b0;
  logic [4:0]  op0 = '0, op1 = '0;
  logic        rsp_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_ops = '0;

  // Reference ALU: ipsel swaps operands; opsel 1 add, 2 and, 3 or, 4 xor,
  // 5 subtract (carry = borrow); any other code passes the first operand.
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic ip, input logic [4:0] op);
    logic [31:0] x, y;
    x = ip ? b : a;
    y = ip ? a : b;
    case (op)
      5'd1:    return {1'b0, x} + {1'b0, y};
      5'd2:    return {1'b0, x & y};
      5'd3:    return {1'b0, x | y};
      5'd4:    return {1'b0, x ^ y};
      5'd5:    return {1'b0, x} - {1'b0, y};
      default: return {1'b0, x};
    endcase
  endfunction

  // Round-robin instance
  logic        rr_rdy0, rr_rdy1, rr_alu_ip, rr_rv, rr_rid, rr_rcy, rr_busy;
  logic [31:0] rr_alu_a, rr_alu_b, rr_rres;
  logic [4:0]  rr_alu_op;
  logic [15:0] rr_ops;
  logic [32:0] rr_alu_out;
  assign rr_alu_out = alu_model(rr_alu_a, rr_alu_b, rr_alu_ip, rr_alu_op);

  alu_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0 & ~sel_fp), .req0_ready(rr_rdy0), .req0_a(a0), .req0_b(b0),
    .req0_ipsel(ip0), .req0_opsel(op0),
    .req1_valid(v1 & ~sel_fp), .req1_ready(rr_rdy1), .req1_a(a1), .req1_b(b1),
    .req1_ipsel(ip1), .req1_opsel(op1),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_ipsel(rr_alu_ip), .alu_opsel(rr_alu_op),
    .alu_result(rr_alu_out[31:0]), .alu_carry(rr_alu_out[32]),
    .rsp_valid(rr_rv), .rsp_ready(rsp_ready), .rsp_id(rr_rid), .rsp_result(rr_rres),
    .rsp_carry(rr_rcy), .busy(rr_busy), .ops_count(rr_ops)
  );

  // Fixed-priority instance
  logic        fp_rdy0, fp_rdy1, fp_alu_ip, fp_rv, fp_rid, fp_rcy, fp_busy;
  logic [31:0] fp_alu_a, fp_alu_b, fp_rres;
  logic [4:0]  fp_alu_op;
  logic [15:0] fp_ops;
  logic [32:0] fp_alu_out;
  assign fp_alu_out = alu_model(fp_alu_a, fp_alu_b, fp_alu_ip, fp_alu_op);

  alu_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v0 & sel_fp), .req0_ready(fp_rdy0), .req0_a(a0), .req0_b(b0),
    .req0_ipsel(ip0), .req0_opsel(op0),
    .req1_valid(v1 & sel_fp), .req1_ready(fp_rdy1), .req1_a(a1), .req1_b(b1),
    .req1_ipsel(ip1), .req1_opsel(op1),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_ipsel(fp_alu_ip), .alu_opsel(fp_alu_op),
    .alu_result(fp_alu_out[31:0]), .alu_carry(fp_alu_out[32]),
    .rsp_valid(fp_rv), .rsp_ready(rsp_ready), .rsp_id(fp_rid), .rsp_result(fp_rres),
    .rsp_carry(fp_rcy), .busy(fp_busy), .ops_count(fp_ops)
  );

  // View of whichever instance is under test
  logic        s_rdy0, s_rdy1, s_alu_ip, s_rv, s_rid, s_rcy, s_busy;
  logic [31:0] s_alu_a, s_alu_b, s_rres;
  logic [4:0]  s_alu_op;
  logic [15:0] s_ops;
  assign s_rdy0   = sel_fp ? fp_rdy0   : rr_rdy0;
  assign s_rdy1   = sel_fp ? fp_rdy1   : rr_rdy1;
  assign s_alu_a  = sel_fp ? fp_alu_a  : rr_alu_a;
  assign s_alu_b  = sel_fp ? fp_alu_b  : rr_alu_b;
  assign s_alu_ip = sel_fp ? fp_alu_ip : rr_alu_ip;
  assign s_alu_op = sel_fp ? fp_alu_op : rr_alu_op;
  assign s_rv     = sel_fp ? fp_rv     : rr_rv;
  assign s_rid    = sel_fp ? fp_rid    : rr_rid;
  assign s_rres   = sel_fp ? fp_rres   : rr_rres;
  assign s_rcy    = sel_fp ? fp_rcy    : rr_rcy;
  assign s_busy   = sel_fp ? fp_busy   : rr_busy;
  assign s_ops    = sel_fp ? fp_ops    : rr_ops;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic        ip;
    logic [4:0]  op;
    logic [31:0] res;
    logic        cy;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        cy;
  } rsp_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset over several edges with both requesters valid; readies must
  // stay low and every output must sit at its reset value.
  task automatic do_reset();
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rsp_ready = 1'b1;
    step(); step();
    @(negedge clk);
    check("reset_ready", {s_rdy0, s_rdy1}, 0);
    check("reset_outputs", {s_rv, s_rid, s_rcy, s_rres, s_busy, s_ops}, 0);
    check("reset_alu", {s_alu_a, s_alu_b, s_alu_ip, s_alu_op}, 0);
    step();
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
    exp_ops = '0;
  endtask

  // One isolated operation, checking accept, EXEC, RESP and return to IDLE
  task automatic run_single(input vec_t v);
    if (v.id) begin
      v1 = 1'b1; a1 = v.a; b1 = v.b; ip1 = v.ip; op1 = v.op;
    end else begin
      v0 = 1'b1; a0 = v.a; b0 = v.b; ip0 = v.ip; op0 = v.op;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("single_ready", {s_rdy0, s_rdy1}, {~v.id, v.id});
    step();
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    check("single_exec_alu", {s_alu_a, s_alu_b, s_alu_ip, s_alu_op}, {v.a, v.b, v.ip, v.op});
    check("single_exec_state", {s_rv, s_busy}, 2'b01);
    step();
    @(negedge clk);
    check("single_rsp", {s_rv, s_rid, s_rcy, s_rres}, {1'b1, v.id, v.cy, v.res});
    step();
    exp_ops = exp_ops + 16'd1;
    @(negedge clk);
    check("single_done", {s_rv, s_busy, s_alu_a, s_alu_b}, 0);
    check("single_ops", s_ops, exp_ops);
    step();
  endtask

  // Random traffic checked against a transaction-level model: pending
  // operations, an outstanding-operation flag, and a response queue.
  task automatic run_random(input logic fp, input int ncyc);
    rsp_t q[$];
    logic        m_busy;
    int          m_last, acc_cyc, win, drop;
    logic [15:0] m_ops;
    logic [31:0] ea, eb;
    logic        eip;
    logic [4:0]  eop;
    logic [32:0] r;
    sel_fp = fp;
    do_reset();
    m_busy = 1'b0; m_last = 1; acc_cyc = 0; drop = -1; m_ops = '0;
    ea = '0; eb = '0; eip = 1'b0; eop = '0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (drop == 0) v0 = 1'b0;
      if (drop == 1) v1 = 1'b0;
      drop = -1;
      if (!v0 && $urandom_range(0, 1) == 1) begin
        v0 = 1'b1; a0 = $urandom; b0 = $urandom;
        ip0 = 1'($urandom_range(0, 1)); op0 = 5'($urandom_range(0, 7));
      end
      if (!v1 && $urandom_range(0, 1) == 1) begin
        v1 = 1'b1; a1 = $urandom; b1 = $urandom;
        ip1 = 1'($urandom_range(0, 1)); op1 = 5'($urandom_range(0, 7));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      win = -1;
      if (!m_busy && (v0 || v1)) begin
        if (v0 && v1) win = fp ? 0 : 1 - m_last;
        else          win = v0 ? 0 : 1;
      end
      check("rand_ready", {s_rdy0, s_rdy1}, {win == 0, win == 1});
      if (m_busy && cyc == acc_cyc + 1)
        check("rand_alu_exec", {s_alu_a, s_alu_b, s_alu_ip, s_alu_op}, {ea, eb, eip, eop});
      else
        check("rand_alu_idle", {s_alu_a, s_alu_b, s_alu_ip, s_alu_op}, 0);
      check("rand_rsp_valid", s_rv, m_busy && cyc >= acc_cyc + 2);
      check("rand_busy", s_busy, m_busy && cyc > acc_cyc);
      check("rand_ops", s_ops, m_ops);
      if (m_busy && cyc >= acc_cyc + 2) begin
        check("rand_rsp", {s_rid, s_rcy, s_rres}, {q[0].id, q[0].cy, q[0].res});
        if (rsp_ready) begin
          void'(q.pop_front());
          m_busy = 1'b0;
          m_ops  = m_ops + 16'd1;
        end
      end else if (win >= 0) begin
        ea  = win == 1 ? a1  : a0;
        eb  = win == 1 ? b1  : b0;
        eip = win == 1 ? ip1 : ip0;
        eop = win == 1 ? op1 : op0;
        r   = alu_model(ea, eb, eip, eop);
        q.push_back('{id: win[0], res: r[31:0], cy: r[32]});
        m_busy = 1'b1; acc_cyc = cyc; m_last = win; drop = win;
      end
      step();
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g[$];
    int rids[$];
    int n1;

    vt[0] = '{id: 1'b0, a: 32'd5,          b: 32'd7,          ip: 1'b0, op: 5'd1, res: 32'd12,         cy: 1'b0};
    vt[1] = '{id: 1'b1, a: 32'hFFFFFFFF,   b: 32'd1,          ip: 1'b0, op: 5'd1, res: 32'd0,          cy: 1'b1};
    vt[2] = '{id: 1'b0, a: 32'hF0F0F0F0,   b: 32'hFF00FF00,   ip: 1'b0, op: 5'd2, res: 32'hF000F000,   cy: 1'b0};
    vt[3] = '{id: 1'b1, a: 32'd3,          b: 32'd10,         ip: 1'b0, op: 5'd5, res: 32'hFFFFFFF9,   cy: 1'b1};
    vt[4] = '{id: 1'b0, a: 32'd3,          b: 32'd10,         ip: 1'b1, op: 5'd5, res: 32'd7,          cy: 1'b0};
    vt[5] = '{id: 1'b1, a: 32'h12345678,   b: 32'h0F0F0F0F,   ip: 1'b0, op: 5'd4, res: 32'h1D3B5977,   cy: 1'b0};
    vt[6] = '{id: 1'b0, a: 32'hA5000000,   b: 32'h005A0000,   ip: 1'b0, op: 5'd3, res: 32'hA55A0000,   cy: 1'b0};

    // Directed single operations (first entry: 5 + 7 -> 12, ops_count 1)
    sel_fp = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) run_single(vt[i]);

    // Round-robin contention: grants and response ids alternate 0,1,0,1
    do_reset();
    v0 = 1'b1; a0 = 32'd1;  b0 = 32'd2;  ip0 = 1'b0; op0 = 5'd1;
    v1 = 1'b1; a1 = 32'd10; b1 = 32'd20; ip1 = 1'b0; op1 = 5'd1;
    rsp_ready = 1'b1;
    g.delete(); rids.delete();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      check("rr_onehot", s_rdy0 & s_rdy1, 0);
      if (s_rdy0) g.push_back(0);
      if (s_rdy1) g.push_back(1);
      if (s_rv) rids.push_back(int'(s_rid));
      step();
    end
    check("rr_grant_count", g.size() >= 4, 1);
    check("rr_rsp_count", rids.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      check("rr_grant_order", i < g.size() ? g[i] : -1, i % 2);
      check("rr_rsp_id_order", i < rids.size() ? rids[i] : -1, i % 2);
    end

    // Fixed priority: requester 0 wins every time
    sel_fp = 1'b1;
    do_reset();
    v0 = 1'b1; v1 = 1'b1; rsp_ready = 1'b1;
    rids.delete(); n1 = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (s_rdy1) n1++;
      if (s_rv) rids.push_back(int'(s_rid));
      step();
    end
    check("fp_req1_ready_count", n1, 0);
    check("fp_rsp_count", rids.size() >= 4, 1);
    for (int i = 0; i < 4; i++) check("fp_rsp_id", i < rids.size() ? rids[i] : -1, 0);

    // Backpressure: AND result held through 5 stalled RESP cycles
    sel_fp = 1'b0;
    do_reset();
    v0 = 1'b1; a0 = 32'hF0F0F0F0; b0 = 32'hFF00FF00; ip0 = 1'b0; op0 = 5'd2;
    v1 = 1'b1; a1 = 32'd1; b1 = 32'd1; ip1 = 1'b0; op1 = 5'd1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_accept", {s_rdy0, s_rdy1}, 2'b10);
    step();
    @(negedge clk);
    check("bp_exec_no_accept", {s_rdy0, s_rdy1, s_rv}, 0);
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold", {s_rv, s_busy, s_rid, s_rcy, s_rres}, {4'b1100, 32'hF000F000});
      check("bp_no_accept", {s_rdy0, s_rdy1}, 0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {s_rv, s_rres}, {1'b1, 32'hF000F000});
    step();
    @(negedge clk);
    check("bp_after_ops", s_ops, 16'd1);
    check("bp_next_grant", {s_rdy0, s_rdy1}, 2'b01);
    step();
    v0 = 1'b0; v1 = 1'b0;

    // Reset during EXEC discards the operation
    do_reset();
    v0 = 1'b1; a0 = 32'd5; b0 = 32'd7; ip0 = 1'b0; op0 = 5'd1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rmid_accept", {s_rdy0, s_rdy1}, 2'b10);
    step();
    v0 = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rmid_in_exec", s_busy, 1);
    step();
    @(negedge clk);
    check("rmid_discard", {s_rv, s_busy, s_ops}, 0);
    step();
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1;
    @(negedge clk);
    check("rmid_first_grant", {s_rdy0, s_rdy1}, 2'b10);
    step();
    v0 = 1'b0; v1 = 1'b0;

    // Counter wrap: preload near the top, then complete two operations
    do_reset();
    force dut_rr.ops_count_q = 16'hFFFE;
    @(negedge clk);
    release dut_rr.ops_count_q;
    check("wrap_preload", s_ops, 16'hFFFE);
    step();
    exp_ops = 16'hFFFE;
    run_single(vt[0]);
    run_single(vt[1]);
    check("wrap_zero", s_ops, 16'h0000);

    // Randomized traffic on both arbitration modes
    run_random(1'b0, 400);
    run_random(1'b1, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
